// File: rtl/mem_block_master.sv
// Initiator-side controller for a single-port synchronous memory block.
// Turns valid/ready single or burst requests into one memory beat per cycle and returns read data.
module mem_block_master #(
  parameter int MEM_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int BURST_WIDTH = 4,
  parameter int RD_LAT      = 1
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   ReqValid,
  output logic                   ReqReady,
  input  logic                   ReqWrite,
  input  logic [ADDR_WIDTH-1:0]  ReqAddr,
  input  logic [BURST_WIDTH-1:0] ReqLen,
  input  logic [MEM_WIDTH-1:0]   WrData,
  input  logic                   WrValid,
  output logic                   WrReady,
  output logic [MEM_WIDTH-1:0]   RdData,
  output logic                   RdValid,
  output logic                   RdLast,
  output logic                   Busy,
  output logic [ADDR_WIDTH-1:0]  MemAddr,
  output logic [MEM_WIDTH-1:0]   MemDataIn,
  output logic                   MemWE,
  input  logic [MEM_WIDTH-1:0]   MemDout
);

  localparam int CNT_W = BURST_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [RD_LAT:0]         pipe_v, pipe_last;
  logic                    issue_v, issue_last;
  logic                    ret_v, ret_last;
  logic                    req_ready_nxt, wr_ready_nxt, busy_nxt, mem_we_nxt;
  logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
  logic [MEM_WIDTH-1:0]    mem_din_nxt;

  // Tag that an issued read address reaches the capture edge RD_LAT+1 edges later.
  assign ret_v    = pipe_v[RD_LAT];
  assign ret_last = pipe_last[RD_LAT];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    state_nxt     = state;
    addr_nxt      = addr;
    cnt_nxt       = cnt;
    req_ready_nxt = 1'b0;
    wr_ready_nxt  = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = MemAddr;
    mem_din_nxt   = MemDataIn;
    issue_v       = 1'b0;
    issue_last    = 1'b0;

    unique case (state)
      IDLE: begin
        req_ready_nxt = 1'b1;
        if (ReqValid && ReqReady) begin
          req_ready_nxt = 1'b0;
          if (ReqWrite) begin
            state_nxt    = WRITE;
            addr_nxt     = ReqAddr;
            cnt_nxt      = CNT_W'(ReqLen) + CNT_W'(1);
            wr_ready_nxt = 1'b1;
          end else begin
            // The first read address goes out on the accept edge itself.
            mem_addr_nxt = ReqAddr;
            issue_v      = 1'b1;
            issue_last   = (ReqLen == '0);
            addr_nxt     = ReqAddr + ADDR_WIDTH'(1);
            cnt_nxt      = CNT_W'(ReqLen);
            state_nxt    = (ReqLen == '0) ? DRAIN : READ;
          end
        end
      end

      WRITE: begin
        wr_ready_nxt = 1'b1;
        if (WrValid && WrReady) begin
          mem_addr_nxt = addr;
          mem_din_nxt  = WrData;
          mem_we_nxt   = 1'b1;
          addr_nxt     = addr + ADDR_WIDTH'(1);
          cnt_nxt      = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            wr_ready_nxt  = 1'b0;
            req_ready_nxt = 1'b1;
            state_nxt     = IDLE;
          end
        end
      end

      READ: begin
        mem_addr_nxt = addr;
        issue_v      = 1'b1;
        issue_last   = (cnt == CNT_W'(1));
        addr_nxt     = addr + ADDR_WIDTH'(1);
        cnt_nxt      = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = DRAIN;
      end

      DRAIN: begin
        if (ret_v && ret_last) begin
          state_nxt     = IDLE;
          req_ready_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE) || issue_v || (|pipe_v[RD_LAT-1:0]);
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values, whatever the statement order.
    if (!Rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      cnt       <= '0;
      ReqReady  <= 1'b1;
      WrReady   <= 1'b0;
      RdValid   <= 1'b0;
      RdLast    <= 1'b0;
      RdData    <= '0;
      Busy      <= 1'b0;
      MemWE     <= 1'b0;
      MemAddr   <= '0;
      MemDataIn <= '0;
      // NOTE: clearing the tag pipeline is what drops in-flight reads; the data path needs no reset for that.
      pipe_v    <= '0;
      pipe_last <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      cnt       <= cnt_nxt;
      ReqReady  <= req_ready_nxt;
      WrReady   <= wr_ready_nxt;
      Busy      <= busy_nxt;
      MemWE     <= mem_we_nxt;
      MemAddr   <= mem_addr_nxt;
      MemDataIn <= mem_din_nxt;
      pipe_v    <= {pipe_v[RD_LAT-1:0], issue_v};
      pipe_last <= {pipe_last[RD_LAT-1:0], issue_last};
      RdValid   <= ret_v;
      RdLast    <= ret_v && ret_last;
      if (ret_v) RdData <= MemDout;
    end
  end

endmodule

// File: tb/tb_mem_block_master.sv
// Bench for mem_block_master: behavioural memory, reference memory image and scoreboard queues
// for expected memory writes and read beats, checked by a free-running monitor.
module tb_mem_block_master;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       ReqValid, ReqReady, ReqWrite;
  logic [7:0] ReqAddr;
  logic [3:0] ReqLen;
  logic [7:0] WrData;
  logic       WrValid, WrReady;
  logic [7:0] RdData;
  logic       RdValid, RdLast, Busy;
  logic [7:0] MemAddr, MemDataIn, MemDout;
  logic       MemWE;

  always #5 Clk = ~Clk;

  mem_block_master #(.MEM_WIDTH(8), .ADDR_WIDTH(8), .BURST_WIDTH(4), .RD_LAT(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqLen(ReqLen),
    .WrData(WrData), .WrValid(WrValid), .WrReady(WrReady),
    .RdData(RdData), .RdValid(RdValid), .RdLast(RdLast), .Busy(Busy),
    .MemAddr(MemAddr), .MemDataIn(MemDataIn), .MemWE(MemWE), .MemDout(MemDout)
  );

  typedef struct {logic [7:0] data; logic last;} rd_exp_t;
  typedef struct {logic [7:0] addr; logic [7:0] data;} wr_exp_t;

  rd_exp_t    rq[$];
  wr_exp_t    wq[$];
  logic [7:0] ref_mem [256];
  logic [7:0] mem [256];
  logic [7:0] wdata[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Single-port memory with registered output, one edge of read latency.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    MemDout = '0;
    forever begin
      @(posedge Clk);
      if (MemWE === 1'b1) mem[MemAddr] <= MemDataIn;
      MemDout <= mem[MemAddr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every read beat and every memory write pulse must match the head of its queue.
  initial begin
    rd_exp_t re;
    wr_exp_t we;
    forever begin
      @(negedge Clk);
      if (RdValid === 1'b1) begin
        if (rq.size() == 0) check("rd_unexpected", RdValid, 0);
        else begin
          re = rq.pop_front();
          check("rd_data", RdData, re.data);
          check("rd_last", RdLast, re.last);
          check("rd_req_ready", ReqReady, re.last);
        end
      end
      if (MemWE === 1'b1) begin
        if (wq.size() == 0) check("we_unexpected", MemWE, 0);
        else begin
          we = wq.pop_front();
          check("we_addr", MemAddr, we.addr);
          check("we_data", MemDataIn, we.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=done");
    $fatal(1);
  end

  task automatic wait_ready(input bit wr_side);
    int n = 0;
    while ((wr_side ? WrReady : ReqReady) !== 1'b1 && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 200) check(wr_side ? "wr_ready_timeout" : "req_ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge Clk);
      if (Busy === 1'b0 && ReqReady === 1'b1 && rq.size() == 0 && wq.size() == 0) done = 1;
    end
    check("idle_reached", done, 1);
  endtask

  // Write burst of wdata; WrValid drops for stall_n cycles before beat stall_at.
  task automatic write_req(input logic [7:0] a, input int stall_at, input int stall_n);
    logic [7:0] ai;
    wait_ready(0);
    for (int i = 0; i < wdata.size(); i++) begin
      ai = a + 8'(i);
      ref_mem[ai] = wdata[i];
      wq.push_back('{ai, wdata[i]});
    end
    ReqValid = 1; ReqWrite = 1; ReqAddr = a; ReqLen = 4'(wdata.size() - 1);
    @(posedge Clk); #1;
    ReqValid = 0;
    for (int i = 0; i < wdata.size(); i++) begin
      if (i == stall_at)
        for (int s = 0; s < stall_n; s++) begin
          @(posedge Clk); @(negedge Clk);
          check("stall_we", MemWE, 0);
        end
      wait_ready(1);
      WrValid = 1; WrData = wdata[i];
      @(posedge Clk); #1;
      WrValid = 0;
    end
  endtask

  task automatic read_req(input logic [7:0] a, input int len);
    rd_exp_t e;
    logic [7:0] ai;
    wait_ready(0);
    for (int i = 0; i <= len; i++) begin
      ai = a + 8'(i);
      e.data = ref_mem[ai];
      e.last = (i == len);
      rq.push_back(e);
    end
    ReqValid = 1; ReqWrite = 0; ReqAddr = a; ReqLen = 4'(len);
    @(posedge Clk); #1;
    ReqValid = 0;
  endtask

  initial begin
    int len;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    Rst_n = 0; ReqValid = 0; ReqWrite = 0; ReqAddr = '0; ReqLen = '0;
    WrData = '0; WrValid = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_req_ready", ReqReady, 1);
    check("rst_wr_ready", WrReady, 0);
    check("rst_rd_valid", RdValid, 0);
    check("rst_rd_last", RdLast, 0);
    check("rst_busy", Busy, 0);
    check("rst_mem_we", MemWE, 0);
    check("rst_mem_addr", MemAddr, 0);
    check("rst_mem_din", MemDataIn, 0);
    check("rst_rd_data", RdData, 0);
    Rst_n = 1;

    // Single write then back-to-back single read with exact latency.
    wdata = '{8'hA5};
    write_req(8'h10, -1, 0);
    read_req(8'h10, 0);
    check("lat_accept", RdValid, 0);
    @(posedge Clk); #1;
    check("lat_edge1", RdValid, 0);
    @(posedge Clk); #1;
    check("lat_edge2_valid", RdValid, 1);
    check("lat_edge2_data", RdData, 8'hA5);
    check("lat_edge2_last", RdLast, 1);
    wait_idle();

    // Burst across the address wrap.
    wdata = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_req(8'hFE, -1, 0);
    read_req(8'hFE, 3);
    wait_idle();

    // Burst with a three-cycle write stall.
    wdata = '{8'hC1, 8'hC2, 8'hC3};
    write_req(8'h80, 1, 3);
    wait_idle();
    read_req(8'h80, 2);
    wait_idle();

    // Fill 0x00..0x0F with data=addr, then a maximum-length read.
    wdata.delete();
    for (int i = 0; i < 16; i++) wdata.push_back(8'(i));
    write_req(8'h00, -1, 0);
    wait_idle();
    read_req(8'h00, 15);
    check("maxlen_busy", Busy, 1);
    wait_idle();

    // Write then immediate read of the same address.
    wdata = '{8'h3C};
    write_req(8'h40, -1, 0);
    read_req(8'h40, 0);
    wait_idle();

    // Reset during beat 2 of an 8-beat read.
    read_req(8'h00, 7);
    repeat (3) @(posedge Clk);
    #1 Rst_n = 0;
    @(posedge Clk); #1;
    Rst_n = 1;
    rq.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("abort_rd_valid", RdValid, 0);
      check("abort_rd_last", RdLast, 0);
      check("abort_req_ready", ReqReady, 1);
      check("abort_busy", Busy, 0);
      check("abort_mem_we", MemWE, 0);
    end

    // Randomized mix of bursts.
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        wdata.delete();
        for (int i = 0; i <= len; i++) wdata.push_back(8'($urandom));
        write_req(8'($urandom), $urandom_range(0, len + 3), $urandom_range(1, 3));
      end else begin
        read_req(8'($urandom), len);
      end
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    check("rq_drained", rq.size(), 0);
    check("wq_drained", wq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
